// File: rtl/proc_imul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_imul_pkg
// Description : Shared state encoding, default width and request field
//               offsets for the iterative MUL sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_imul_pkg;

    localparam int IMUL_NBITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IMUL_IDLE = 2'd0,
        IMUL_CALC = 2'd1,
        IMUL_DONE = 2'd2
    } imul_state_e;

    // Request message is {a, b}: b occupies the low half, a the high half.
    localparam int IMUL_REQ_B_LSB = 0;

    function automatic int imul_req_a_lsb(input int nbits);
        return nbits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_imul_dpath.sv
`default_nettype none
// ============================================================================
// Module      : proc_imul_dpath
// Description : Operand/accumulator registers, shifters and the single adder
//               of the shift-add multiplier. PROC_IMUL_EARLY_EXIT_EN enables
//               the remaining-multiplier zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_imul_dpath
    import proc_imul_pkg::*;
#(
    parameter int NBITS = IMUL_NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [NBITS-1:0] i_a,
    input  logic [NBITS-1:0] i_b,
    output logic [NBITS-1:0] o_result,
    output logic             o_b_next_zero
);

    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic [NBITS-1:0] r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else if (i_load) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_result <= '0;
        end else if (i_step) begin
            // Accumulation wraps naturally: only the low NBITS bits are kept.
            if (r_b[0]) begin
                r_result <= r_result + r_a;
            end
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
        end
    end

    assign o_result = r_result;

`ifdef PROC_IMUL_EARLY_EXIT_EN
    assign o_b_next_zero = (r_b[NBITS-1:1] == '0);
`else
    assign o_b_next_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/proc_imul_seq.sv
`default_nettype none
// ============================================================================
// Module      : proc_imul_seq
// Description : Iterative shift-add MUL sequencer with val/rdy request and
//               response ports; returns the low NBITS bits of a*b.
//               Optional macro PROC_IMUL_EARLY_EXIT_EN ends CALC once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_imul_seq
    import proc_imul_pkg::*;
#(
    parameter int NBITS = IMUL_NBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2*NBITS-1:0] req_msg,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [NBITS-1:0]   resp_msg
);

    localparam int                 c_cnt_w    = $clog2(NBITS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(NBITS - 1);
    localparam int                 c_a_lsb    = imul_req_a_lsb(NBITS);

    imul_state_e        r_state;
    imul_state_e        w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_load;
    logic               w_step;
    logic               w_b_next_zero;
    logic [NBITS-1:0]   w_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IMUL_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            // Counter wraps to 0 on the final CALC cycle by construction.
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        req_rdy      = 1'b0;
        resp_val     = 1'b0;
        case (r_state)
            IMUL_IDLE: begin
                req_rdy = !reset;
                if (req_val) begin
                    w_load       = 1'b1;
                    w_state_next = IMUL_CALC;
                end
            end
            IMUL_CALC: begin
                w_step = 1'b1;
                if ((r_cnt == c_cnt_last) || w_b_next_zero) begin
                    w_state_next = IMUL_DONE;
                end
            end
            IMUL_DONE: begin
                resp_val = !reset;
                if (resp_rdy) begin
                    w_state_next = IMUL_IDLE;
                end
            end
            default: begin
                w_state_next = IMUL_IDLE;
            end
        endcase
    end

    proc_imul_dpath #(
        .NBITS (NBITS)
    ) u_dpath (
        .clk           (clk),
        .rst           (reset),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_a           (req_msg[c_a_lsb +: NBITS]),
        .i_b           (req_msg[IMUL_REQ_B_LSB +: NBITS]),
        .o_result      (w_result),
        .o_b_next_zero (w_b_next_zero)
    );

    assign resp_msg = w_result;

endmodule
`default_nettype wire

// File: tb/tb_proc_imul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_imul_seq
// Description : Self-checking bench for proc_imul_seq: vector table plus
//               backpressure and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_imul_seq;

`ifdef PROC_IMUL_EARLY_EXIT_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [63:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_msg;

    int n_checks;
    int n_errors;

    proc_imul_seq #(
        .NBITS (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Cycles from the request edge to the first cycle with resp_val high.
    function automatic int exp_lat(input logic [31:0] b);
        int hi;
        hi = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) hi = i + 1;
        end
        return c_early ? hi : 32;
    endfunction

    // Called at a negedge; returns at the negedge after the response transfer.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold);
        int n;
        int lat;
        bit rdy_bad;
        bit bp_bad;
        n = 0;
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_rdy before request", 32'(req_rdy), 32'd1);
        req_msg = {a, b};
        req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        req_msg = '0;
        lat     = 0;
        rdy_bad = 1'b0;
        @(negedge clk);
        while (!resp_val && lat < 200) begin
            if (req_rdy !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("req_rdy low while busy", 32'(rdy_bad), 32'd0);
        check("latency", 32'(lat), 32'(exp_lat(b)));
        check("product", resp_msg, exp);
        bp_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_val !== 1'b1 || resp_msg !== exp || req_rdy !== 1'b0) bp_bad = 1'b1;
        end
        if (hold > 0) check("backpressure hold", 32'(bp_bad), 32'd0);
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        resp_rdy = 1'b0;
        @(negedge clk);
        check("idle after response", 32'({req_rdy, resp_val}), 32'b10);
    endtask

    initial begin
        vec_t vecs[9];
        bit   stray;

        clk      = 1'b0;
        reset    = 1'b1;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b0;
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{32'd3,        32'd4,        32'd12};
        vecs[1] = '{32'hFFFFFFFF, 32'd5,        32'hFFFFFFFB};
        vecs[2] = '{32'h80000000, 32'd2,        32'h00000000};
        vecs[3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
        vecs[4] = '{32'd7,        32'd2,        32'd14};
        vecs[5] = '{32'd5,        32'd0,        32'd0};
        vecs[6] = '{32'd1,        32'h80000000, 32'h80000000};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[8] = '{32'h00010000, 32'h00010000, 32'h00000000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("outputs during reset", 32'({req_rdy, resp_val}), 32'b00);
        reset = 1'b0;
        @(negedge clk);
        check("outputs after reset", 32'({req_rdy, resp_val}), 32'b10);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0);
        end

        // Backpressure then a request accepted in the first IDLE cycle.
        run_op(32'd7, 32'd6, 32'd42, 5);
        run_op(32'd11, 32'd13, 32'd143, 0);

        // Abort at CALC cycle 10 with reset.
        req_msg = {32'hFFFF0000, 32'hFFFFFFFF};
        req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        req_msg = '0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid-op reset outputs", 32'({req_rdy, resp_val}), 32'b00);
        @(posedge clk);
        @(negedge clk);
        check("mid-op reset held", 32'({req_rdy, resp_val}), 32'b00);
        reset = 1'b0;
        @(negedge clk);
        check("after mid-op reset", 32'({req_rdy, resp_val}), 32'b10);
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_val !== 1'b0) stray = 1'b1;
        end
        check("no response after abort", 32'(stray), 32'd0);
        run_op(32'd2, 32'd9, 32'd18, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_imul_seq.md
Name: proc_imul_seq

Overview:
- Iterative shift-add multiplier sequencer serving the processor's MUL instruction; it returns the low NBITS bits of the product.
- Contains an FSM, an iteration counter, and operand/accumulator registers driving one adder.
- Sits beside the X stage and talks to the pipeline control through val/rdy request and response interfaces.
- The pipeline stalls in X until the response handshake completes.

Parameters:
- NBITS, 32, operand and result width; must be a power of 2 and at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_msg  in  2*NBITS  {a, b}; a in the upper half, b in the lower half.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_msg  out  NBITS  product, (a*b) mod 2^NBITS.

Behaviour:
- Reset:
  - State goes to IDLE, counter to 0, and the a/b/result registers to 0.
  - While reset is high, req_rdy=0 and resp_val=0.
  - The cycle after reset deasserts, req_rdy=1 and resp_val=0.
  - Reset at any point, including mid-CALC or in DONE, aborts the operation. No response is produced for it.
- Handshake:
  - A transfer occurs when val and rdy are both high at a rising edge.
  - Neither req_rdy nor resp_val depends combinationally on req_val or resp_rdy. Both are pure state decode gated by !reset.
- States:
  - IDLE:
    - req_rdy=1, resp_val=0.
    - On a request transfer, load a<=req_msg[2N-1:N], b<=req_msg[N-1:0], result<=0, counter<=0, then go to CALC.
  - CALC (req_rdy=0, resp_val=0), each cycle:
    - if b[0], result<=result+a (mod 2^NBITS);
    - a<=a<<1;
    - b<=b>>1 (logical);
    - counter<=counter+1.
    - When counter==NBITS-1 during this cycle, go to DONE.
  - DONE:
    - resp_val=1, resp_msg=result.
    - On a response transfer, go to IDLE.
    - Otherwise hold; resp_msg stays stable under backpressure.
- Latency:
  - A request accepted at edge t gives resp_val=1 in the cycle after edge t+NBITS. CALC lasts exactly NBITS cycles.
- Throughput:
  - No overlap between operations; the next request is accepted no earlier than the cycle after the response transfer.
  - The minimum initiation interval is NBITS+2 cycles.
- Boundaries:
  - The counter is $clog2(NBITS) bits wide and wraps to 0 on the final CALC cycle. The value is unused afterwards.
  - A request arriving in CALC or DONE is ignored (req_rdy=0) and the requester must hold it.
  - Operands are treated as bit patterns; the low half is identical for signed and unsigned inputs.

Optional Feature:
- Macro: PROC_IMUL_EARLY_EXIT_EN.
- Defined:
  - In CALC, also go to DONE when the post-shift value (b>>1) is zero.
  - b=0 at load therefore takes 1 CALC cycle (resp_val in the cycle after edge t+1).
  - Generally, CALC lasts max(1, index of the highest set bit of b + 1) cycles.
  - The result is identical to the fixed-latency result.
- Undefined:
  - Fixed NBITS-cycle CALC as specified above.
  - No zero-detect logic is synthesised.

Decomposition:
- Shared package proc_imul_pkg holds:
  - state enum {IMUL_IDLE, IMUL_CALC, IMUL_DONE}, encoded 2'd0/1/2;
  - localparam IMUL_NBITS_DEFAULT=32;
  - request message field offsets.
- One sub-module, proc_imul_dpath, holds:
  - the a/b/result registers, shifters and adder;
  - the b-zero detect output (b>>1 == 0).
- The top level holds the FSM and counter and drives the dpath load/enable controls.

Test Plan:
- 3*4: req_msg={32'd3,32'd4} accepted at edge t -> resp_val first high after edge t+32, resp_msg=32'd12; req_rdy=0 from t+1 until after the response transfer.
- 0xFFFFFFFF*5 -> resp_msg=0xFFFFFFFB.
- 0x80000000*2 -> resp_msg=0x00000000.
- 0x0000FFFF*0x0000FFFF -> 0xFFFE0001.
- Backpressure:
  - 7*6 with resp_rdy=0 for 5 cycles in DONE -> resp_val stays 1 and resp_msg stays 32'd42 throughout.
  - Release resp_rdy -> IDLE next cycle, and a back-to-back request is accepted that cycle.
- Reset mid-operation:
  - Assert reset at CALC cycle 10 -> no response; req_rdy=0 during reset and 1 the cycle after.
  - Then 2*9 -> 32'd18 with full latency.
- With PROC_IMUL_EARLY_EXIT_EN:
  - 7*2 -> 2 CALC cycles, resp_val after edge t+2, resp_msg=14.
  - 5*0 -> 1 CALC cycle, resp_msg=0.
  - 1*0x80000000 -> 32 CALC cycles, resp_msg=0x80000000.
